// File: rtl/spi_master_tx_if.sv
// Handshake and data bundle between the SPI TX shifter, its TX FIFO,
// the SPI clock generator and the transfer controller.
interface spi_master_tx_if #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  en_i;
    logic                  tx_edge_i;
    logic                  en_quad_i;
    logic [CNT_WIDTH-1:0]  counter_in_i;
    logic                  counter_in_upd_i;
    logic [DATA_WIDTH-1:0] txdata_i;
    logic                  txdata_valid_i;
    logic                  txdata_ready_o;
    logic                  sdo0_o;
    logic                  sdo1_o;
    logic                  sdo2_o;
    logic                  sdo3_o;
    logic                  clk_en_o;
    logic                  tx_done_o;

    // Controller / FIFO / clock-generator side
    modport master (
        output en_i, tx_edge_i, en_quad_i, counter_in_i, counter_in_upd_i,
               txdata_i, txdata_valid_i,
        input  txdata_ready_o, sdo0_o, sdo1_o, sdo2_o, sdo3_o,
               clk_en_o, tx_done_o
    );

    // Transmit shifter side
    modport slave (
        input  en_i, tx_edge_i, en_quad_i, counter_in_i, counter_in_upd_i,
               txdata_i, txdata_valid_i,
        output txdata_ready_o, sdo0_o, sdo1_o, sdo2_o, sdo3_o,
               clk_en_o, tx_done_o
    );
endinterface

// File: rtl/spi_master_tx.sv
// SPI master transmit shifter: pulls 32-bit words from the TX FIFO and
// shifts them out 1 bit (standard) or 4 bits (quad) per SPI launch edge.
module spi_master_tx #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    spi_master_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSMIT = 2'd1,
        STALL    = 2'd2
    } state_e;

    state_e                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  r_tgt;
    logic [DATA_WIDTH-1:0] r_sr;
    logic                  r_quad;
    logic                  r_clk_en;

    logic [CNT_WIDTH-1:0]  w_last_cnt;
    logic                  w_step;
    logic                  w_last;
    logic                  w_word_end;
    logic                  w_done;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_sr_shift;

    // A zero target behaves as a single-step transfer.
    always_comb begin
        w_last_cnt = (r_tgt == '0) ? '0 : r_tgt - CNT_WIDTH'(1);
        w_step     = (r_state == TRANSMIT) && bus.tx_edge_i;
        w_last     = (r_cnt == w_last_cnt);
        w_word_end = r_quad ? (r_cnt[2:0] == 3'b111) : (r_cnt[4:0] == 5'b11111);
        w_done     = w_step && w_last;
        w_sr_shift = r_quad ? {r_sr[DATA_WIDTH-5:0], 4'b0000}
                            : {r_sr[DATA_WIDTH-2:0], 1'b0};
    end

    // Pop strobe mirrors exactly the cycles in which the FSM loads a word.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            IDLE:     w_pop = bus.en_i && bus.txdata_valid_i;
            TRANSMIT: w_pop = w_step && !w_last && w_word_end && bus.txdata_valid_i;
            STALL:    w_pop = bus.txdata_valid_i;
            default:  w_pop = 1'b0;
        endcase
        w_pop = w_pop && rst_ni;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tgt    <= '0;
            r_sr     <= '0;
            r_quad   <= 1'b0;
            r_clk_en <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_clk_en <= 1'b0;
                    if (bus.counter_in_upd_i) begin
                        r_tgt <= bus.en_quad_i ? (bus.counter_in_i >> 2) : bus.counter_in_i;
                    end
                    if (bus.en_i && bus.txdata_valid_i) begin
                        r_sr     <= bus.txdata_i;
                        r_quad   <= bus.en_quad_i;
                        r_cnt    <= '0;
                        r_state  <= TRANSMIT;
                        r_clk_en <= 1'b1;
                    end
                end
                TRANSMIT: begin
                    if (bus.tx_edge_i) begin
                        if (w_last) begin
                            // Residual bits of a partial last word are dropped here.
                            r_sr     <= '0;
                            r_cnt    <= '0;
                            r_state  <= IDLE;
                            r_clk_en <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_WIDTH'(1);
                            if (w_word_end && bus.txdata_valid_i) begin
                                r_sr <= bus.txdata_i;
                            end else if (w_word_end) begin
                                r_sr     <= w_sr_shift;
                                r_state  <= STALL;
                                r_clk_en <= 1'b0;
                            end else begin
                                r_sr <= w_sr_shift;
                            end
                        end
                    end
                end
                STALL: begin
                    if (bus.txdata_valid_i) begin
                        r_sr     <= bus.txdata_i;
                        r_state  <= TRANSMIT;
                        r_clk_en <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_clk_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.txdata_ready_o = w_pop;
    assign bus.tx_done_o      = w_done && rst_ni;
    assign bus.clk_en_o       = r_clk_en;
    assign bus.sdo0_o         = r_quad ? r_sr[DATA_WIDTH-4] : r_sr[DATA_WIDTH-1];
    assign bus.sdo1_o         = r_quad & r_sr[DATA_WIDTH-3];
    assign bus.sdo2_o         = r_quad & r_sr[DATA_WIDTH-2];
    assign bus.sdo3_o         = r_quad & r_sr[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a FIFO queue plus a bit-stream reference model
// (step k carries bits of word k/steps_per_word, MSB first).
module tb_spi_master_tx;

    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    spi_master_tx_if #(.CNT_WIDTH(CW), .DATA_WIDTH(32)) bus ();

    spi_master_tx #(.CNT_WIDTH(CW), .DATA_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    int          pops = 0;
    logic        s_ready, s_done, s_clk_en, s_valid;
    logic [3:0]  s_sdo;

    function automatic logic [3:0] sdo_bus();
        return {bus.sdo3_o, bus.sdo2_o, bus.sdo1_o, bus.sdo0_o};
    endfunction

    task automatic drive_fifo(input bit hold);
        bus.txdata_valid_i = (q.size() != 0) && !hold;
        bus.txdata_i       = (q.size() != 0) ? q[0] : 32'h0;
    endtask

    // One clock: sample at negedge, then pop the bench FIFO after the edge.
    task automatic cyc();
        @(negedge clk);
        s_ready  = bus.txdata_ready_o;
        s_done   = bus.tx_done_o;
        s_clk_en = bus.clk_en_o;
        s_valid  = bus.txdata_valid_i;
        s_sdo    = sdo_bus();
        @(posedge clk);
        #1;
        if (s_ready) begin
            pops++;
            if (q.size() != 0) void'(q.pop_front());
        end
    endtask

    task automatic idle_inputs();
        bus.en_i             = 1'b0;
        bus.tx_edge_i        = 1'b0;
        bus.en_quad_i        = 1'b0;
        bus.counter_in_i     = '0;
        bus.counter_in_upd_i = 1'b0;
        bus.txdata_i         = '0;
        bus.txdata_valid_i   = 1'b0;
    endtask

    // Full transfer against the reference model; words come from q.
    task automatic run_xfer(input bit quad, input int cnt_in, input int period,
                            input int stall_cycles, input bit mid_upd, input string tag);
        int          n, spw, exp_pops, k, p0, hold_left, tc, budget, wsz;
        logic [31:0] ws[$];
        logic [31:0] w;
        logic [3:0]  exp_sym;
        bit          done_seen, edge_now, hold, stall_chk;
        n = quad ? (cnt_in >> 2) : cnt_in;
        if (n == 0) n = 1;
        spw       = quad ? 8 : 32;
        exp_pops  = (n + spw - 1) / spw;
        ws        = q;
        wsz       = q.size();
        p0        = pops;
        k         = 0;
        done_seen = 1'b0;
        hold_left = stall_cycles;
        tc        = 0;

        bus.en_quad_i        = quad;
        bus.counter_in_i     = CW'(cnt_in);
        bus.counter_in_upd_i = 1'b1;
        bus.en_i             = 1'b0;
        bus.tx_edge_i        = 1'b0;
        drive_fifo(1'b1);
        cyc();
        bus.counter_in_upd_i = 1'b0;

        budget = n * period * 2 + stall_cycles + 50;
        for (int c = 0; c < budget && !done_seen; c++) begin
            hold = (stall_cycles > 0) && (pops - p0 == 1) && (hold_left > 0);
            drive_fifo(hold);
            bus.en_i = (pops == p0);
            edge_now = bus.clk_en_o && (tc % period == 0);
            tc++;
            bus.tx_edge_i = edge_now;
            if (mid_upd && k == 2) begin
                bus.counter_in_upd_i = 1'b1;
                bus.counter_in_i     = CW'(cnt_in + 40);
            end else begin
                bus.counter_in_upd_i = 1'b0;
            end
            stall_chk = hold && (k == spw) && (n > spw);
            cyc();
            if (stall_chk) begin
                hold_left--;
                checks++;
                if (s_clk_en !== 1'b0 || s_sdo !== 4'h0) begin
                    errors++;
                    $display("FAIL %s stall clk_en=%b sdo=%h want clk_en=0 sdo=0", tag, s_clk_en, s_sdo);
                end
            end
            checks++;
            if (s_ready && !s_valid) begin
                errors++;
                $display("FAIL %s ready_without_valid got ready=1 want 0", tag);
            end
            if (edge_now) begin
                w = (k / spw < wsz) ? ws[k / spw] : 32'h0;
                exp_sym = quad ? 4'((w >> (28 - 4 * (k % spw))) & 32'hF)
                               : {3'b000, w[31 - (k % spw)]};
                checks++;
                if (s_sdo !== exp_sym) begin
                    errors++;
                    $display("FAIL %s sym[%0d] got %h want %h", tag, k, s_sdo, exp_sym);
                end
                checks++;
                if (s_done !== (k == n - 1)) begin
                    errors++;
                    $display("FAIL %s done[%0d] got %b want %b", tag, k, s_done, (k == n - 1));
                end
                if (k == n - 1) done_seen = 1'b1;
                k++;
            end else begin
                checks++;
                if (s_done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_off_edge got 1 want 0 at step %0d", tag, k);
                end
            end
        end
        bus.counter_in_upd_i = 1'b0;
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s timeout got %0d steps want %0d", tag, k, n);
        end

        bus.tx_edge_i = 1'b0;
        bus.en_i      = 1'b0;
        drive_fifo(1'b0);
        cyc();
        checks++;
        if (s_clk_en !== 1'b0 || s_sdo !== 4'h0 || s_done !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done got clk_en=%b sdo=%h done=%b ready=%b want all 0",
                     tag, s_clk_en, s_sdo, s_done, s_ready);
        end
        checks++;
        if (pops - p0 != exp_pops) begin
            errors++;
            $display("FAIL %s pops got %0d want %0d", tag, pops - p0, exp_pops);
        end
        checks++;
        if (q.size() != wsz - exp_pops) begin
            errors++;
            $display("FAIL %s fifo_left got %0d want %0d", tag, q.size(), wsz - exp_pops);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        bus.en_i           = 1'b1;
        bus.txdata_valid_i = 1'b1;
        bus.txdata_i       = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({bus.txdata_ready_o, bus.tx_done_o, bus.clk_en_o, sdo_bus()} !== 7'h0) begin
                errors++;
                $display("FAIL reset_outputs got ready=%b done=%b clk_en=%b sdo=%h want all 0",
                         bus.txdata_ready_o, bus.tx_done_o, bus.clk_en_o, sdo_bus());
            end
        end
        idle_inputs();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_std_basic();
        q.delete();
        q.push_back(32'hA500_0000);
        run_xfer(1'b0, 8, 4, 0, 1'b0, "std8");
    endtask

    task automatic test_quad();
        q.delete();
        q.push_back(32'h1234_5678);
        q.push_back(32'h9ABC_DEF0);
        run_xfer(1'b1, 64, 2, 0, 1'b0, "quad64");
    endtask

    task automatic test_stall();
        q.delete();
        q.push_back($urandom);
        q.push_back($urandom);
        run_xfer(1'b0, 64, 3, 10, 1'b0, "stall64");
    endtask

    task automatic test_exact_word();
        logic [31:0] w1;
        w1 = $urandom;
        q.delete();
        q.push_back($urandom);
        q.push_back(w1);
        run_xfer(1'b0, 32, 1, 0, 1'b0, "std32");
        checks++;
        if (q.size() == 0 || q[0] !== w1) begin
            errors++;
            $display("FAIL std32 second_word_kept got size=%0d want %h at head", q.size(), w1);
        end
    endtask

    task automatic test_zero_len();
        q.delete();
        q.push_back(32'h8000_0001);
        run_xfer(1'b0, 0, 2, 0, 1'b0, "zero_std");
        q.delete();
        q.push_back(32'hB000_0000);
        run_xfer(1'b1, 3, 1, 0, 1'b0, "zero_quad");
    endtask

    task automatic test_reset_mid();
        int  edges, tc;
        bit  edge_now;
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back($urandom);
        bus.en_quad_i        = 1'b0;
        bus.counter_in_i     = CW'(16);
        bus.counter_in_upd_i = 1'b1;
        drive_fifo(1'b1);
        cyc();
        bus.counter_in_upd_i = 1'b0;
        edges = 0;
        tc    = 0;
        for (int c = 0; c < 100 && edges < 5; c++) begin
            drive_fifo(1'b0);
            bus.en_i      = (edges == 0) && !bus.clk_en_o;
            edge_now      = bus.clk_en_o && (tc % 2 == 0);
            tc++;
            bus.tx_edge_i = edge_now;
            cyc();
            if (edge_now) edges++;
        end
        checks++;
        if (edges != 5) begin
            errors++;
            $display("FAIL rst_mid edges_before_reset got %0d want 5", edges);
        end
        bus.en_i      = 1'b1;
        bus.tx_edge_i = 1'b1;
        drive_fifo(1'b0);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({bus.txdata_ready_o, bus.tx_done_o, bus.clk_en_o, sdo_bus()} !== 7'h0) begin
            errors++;
            $display("FAIL rst_mid immediate got ready=%b done=%b clk_en=%b sdo=%h want all 0",
                     bus.txdata_ready_o, bus.tx_done_o, bus.clk_en_o, sdo_bus());
        end
        repeat (3) begin
            cyc();
            checks++;
            if (s_ready !== 1'b0 || s_done !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid held got ready=%b done=%b want 0 0", s_ready, s_done);
            end
        end
        idle_inputs();
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        run_xfer(1'b0, 16, 2, 0, 1'b0, "post_reset");
    endtask

    task automatic test_upd_ignored();
        q.delete();
        q.push_back($urandom);
        q.push_back($urandom);
        run_xfer(1'b0, 40, 2, 0, 1'b1, "upd_mid");
    endtask

    task automatic test_random();
        bit quad;
        int n, spw, cnt_in, nwords, stall;
        for (int it = 0; it < 20; it++) begin
            quad   = 1'($urandom_range(0, 1));
            n      = $urandom_range(1, 80);
            spw    = quad ? 8 : 32;
            cnt_in = quad ? (n * 4 + $urandom_range(0, 3)) : n;
            nwords = (n + spw - 1) / spw + $urandom_range(0, 1);
            stall  = (n > spw && $urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
            q.delete();
            for (int i = 0; i < nwords; i++) q.push_back($urandom);
            run_xfer(quad, cnt_in, $urandom_range(1, 4), stall,
                     1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_std_basic();
        test_quad();
        test_stall();
        test_exact_word();
        test_zero_len();
        test_reset_mid();
        test_upd_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
